// File: rtl/quad_step_gen.sv
// Quadrature A/B front end: synchronise, glitch-filter, decode Gray steps into
// a single-cycle count-enable pulse plus direction, flagging illegal jumps.
module quad_step_gen #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic       CLK,
    input  logic       CD,
    input  logic       A,
    input  logic       B,
    input  logic       EN,
    input  logic       CS,
    output logic       CNT_EN,
    output logic       DNUP,
    output logic       ERR,
    output logic [1:0] QST
);

    localparam int CW = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    state_t state_r, state_s;

    logic [SYNC_STAGES-1:0] sync_a_r, sync_b_r;
    logic [CW-1:0]          cnt_a_r, cnt_b_r, init_cnt_r;
    logic                   step_r, dir_r, bad_r;
    logic                   sa_s, sb_s, diff_a_s, diff_b_s, acc_a_s, acc_b_s;
    logic                   settled_s, step_s, dir_s, bad_s;
    logic [1:0]             qst_next_s, delta_s;

    // Position of {A,B} along the up-count ring 00 -> 10 -> 11 -> 01.
    function automatic logic [1:0] ring_pos(input logic [1:0] ab);
        return {ab[0], ab[1] ^ ab[0]};
    endfunction

    // Input synchroniser chains.
    always_ff @(posedge CLK or posedge CD) begin
        if (CD) begin
            sync_a_r <= '0;
            sync_b_r <= '0;
        end else begin
            sync_a_r <= {sync_a_r[SYNC_STAGES-2:0], A};
            sync_b_r <= {sync_b_r[SYNC_STAGES-2:0], B};
        end
    end

    // Filter acceptance decisions and the resulting next filtered state.
    always_comb begin
        sa_s       = sync_a_r[SYNC_STAGES-1];
        sb_s       = sync_b_r[SYNC_STAGES-1];
        diff_a_s   = (sa_s != QST[1]);
        diff_b_s   = (sb_s != QST[0]);
        acc_a_s    = diff_a_s && (cnt_a_r == CNT_LAST) && !CS;
        acc_b_s    = diff_b_s && (cnt_b_r == CNT_LAST) && !CS;
        qst_next_s = {(acc_a_s ? sa_s : QST[1]), (acc_b_s ? sb_s : QST[0])};
        // Whole chain must agree so stale reset zeros are not mistaken for a level.
        settled_s  = (sync_a_r == {SYNC_STAGES{QST[1]}}) &&
                     (sync_b_r == {SYNC_STAGES{QST[0]}});
    end

    // Per-channel glitch filter counters and the filtered state.
    always_ff @(posedge CLK or posedge CD) begin
        if (CD) begin
            cnt_a_r <= '0;
            cnt_b_r <= '0;
            QST     <= 2'b00;
        end else if (CS) begin
            cnt_a_r <= '0;
            cnt_b_r <= '0;
        end else begin
            cnt_a_r <= (!diff_a_s || acc_a_s) ? '0 : cnt_a_r + CNT_ONE;
            cnt_b_r <= (!diff_b_s || acc_b_s) ? '0 : cnt_b_r + CNT_ONE;
            QST     <= qst_next_s;
        end
    end

    // FSM state register and INIT stability counter.
    always_ff @(posedge CLK or posedge CD) begin
        if (CD) begin
            state_r    <= ST_INIT;
            init_cnt_r <= '0;
        end else begin
            state_r <= state_s;
            if (CS || (state_r != ST_INIT) || !settled_s) begin
                init_cnt_r <= '0;
            end else begin
                init_cnt_r <= init_cnt_r + CNT_ONE;
            end
        end
    end

    // Next state and step classification of each filtered-state update.
    always_comb begin
        state_s = state_r;
        step_s  = 1'b0;
        dir_s   = 1'b0;
        bad_s   = 1'b0;
        delta_s = ring_pos(qst_next_s) - ring_pos(QST);
        case (state_r)
            ST_INIT: begin
                if (CS) begin
                    state_s = ST_INIT;
                end else if (acc_a_s || acc_b_s) begin
                    state_s = ST_TRACK;
                end else if (settled_s && (init_cnt_r == CNT_LAST)) begin
                    state_s = ST_TRACK;
                end else begin
                    state_s = ST_INIT;
                end
            end
            ST_TRACK: begin
                if (CS) begin
                    state_s = ST_INIT;
                end else if (acc_a_s || acc_b_s) begin
                    case (delta_s)
                        2'd1:    step_s = 1'b1;
                        2'd3: begin
                            step_s = 1'b1;
                            dir_s  = 1'b1;
                        end
                        2'd2:    bad_s  = 1'b1;
                        default: step_s = 1'b0;
                    endcase
                end else begin
                    state_s = ST_TRACK;
                end
            end
            default: state_s = ST_INIT;
        endcase
    end

    // Registered step pipeline and outputs; CS wins over any pending event.
    always_ff @(posedge CLK or posedge CD) begin
        if (CD) begin
            step_r <= 1'b0;
            dir_r  <= 1'b0;
            bad_r  <= 1'b0;
            CNT_EN <= 1'b0;
            DNUP   <= 1'b0;
            ERR    <= 1'b0;
        end else if (CS) begin
            step_r <= 1'b0;
            dir_r  <= 1'b0;
            bad_r  <= 1'b0;
            CNT_EN <= 1'b0;
            ERR    <= 1'b0;
        end else begin
            step_r <= step_s;
            dir_r  <= dir_s;
            bad_r  <= bad_s;
            CNT_EN <= step_r & EN;
            if (step_r) begin
                DNUP <= dir_r;
            end
            if (bad_r) begin
                ERR <= 1'b1;
            end
        end
    end

endmodule
